// File: rtl/dac_out_pkg.sv
// Shared types and constants for the DAC output stage.
// Optional build macro: DAC_OFFSET_BINARY_EN selects offset-binary DAC codes
// (MSB inverted); left undefined, codes are plain two's complement.
package dac_out_pkg;

  // Soft-mute gain FSM states
  typedef enum logic [1:0] {
    UNMUTED   = 2'd0,
    RAMP_DOWN = 2'd1,
    MUTED     = 2'd2,
    RAMP_UP   = 2'd3
  } gain_state_e;

  localparam int NUM_CH     = 2;
  localparam int IN_W       = 16;
  localparam int GAIN_W     = 9;
  localparam int GAIN_UNITY = 256;
  localparam int PROD_W     = 26;
  localparam int FRAC_W     = 8;
  localparam int OUT_W      = 14;
  localparam int OUT_MAX    = 8191;
  localparam int OUT_MIN    = -8192;
  localparam int CNT_W      = 16;

  // DAC code for a silent output, matching the selected code format
`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [OUT_W-1:0] DAC_ZERO = 14'h2000;
`else
  localparam logic [OUT_W-1:0] DAC_ZERO = 14'h0000;
`endif

  // Map a saturated two's-complement value onto the DAC pin code
  function automatic logic [OUT_W-1:0] dac_format(input logic signed [OUT_W-1:0] v);
    logic [OUT_W-1:0] code;
    code = v;
`ifdef DAC_OFFSET_BINARY_EN
    code[OUT_W-1] = ~code[OUT_W-1];
`endif
    return code;
  endfunction

endpackage

// File: rtl/dac_out_stage_if.sv
// Sample/control bundle between the filter core and the DAC output stage.
// The slave modport is the output stage; the master modport is its driver.
interface dac_out_stage_if;
  import dac_out_pkg::*;

  logic signed [IN_W-1:0]  in_a;
  logic signed [IN_W-1:0]  in_b;
  logic                    in_valid;
  logic                    mute;
  logic                    clip_clr;
  logic [OUT_W-1:0]        HSMC_DA;
  logic [OUT_W-1:0]        HSMC_DB;
  logic                    out_valid;
  logic                    muted;
  logic                    clip_a;
  logic                    clip_b;
  logic [CNT_W-1:0]        clip_cnt;

  modport master (
    output in_a, in_b, in_valid, mute, clip_clr,
    input  HSMC_DA, HSMC_DB, out_valid, muted, clip_a, clip_b, clip_cnt
  );

  modport slave (
    input  in_a, in_b, in_valid, mute, clip_clr,
    output HSMC_DA, HSMC_DB, out_valid, muted, clip_a, clip_b, clip_cnt
  );

endinterface

// File: rtl/dac_chan_scale.sv
// One channel of the output stage: gain multiply and floor shift (registered),
// then saturation to 14 bits and DAC code formatting (combinational, registered
// by the parent). Code format follows DAC_OFFSET_BINARY_EN via dac_format().
module dac_chan_scale
  import dac_out_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic signed [IN_W-1:0]   i_sample,
  input  logic [GAIN_W-1:0]        i_gain,
  output logic [OUT_W-1:0]         o_code,
  output logic                     o_clip
);

  localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(OUT_MAX);
  localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(OUT_MIN);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_shift;
  logic signed [OUT_W-1:0]  w_sat;

  // Gain is unsigned, so it gets a zero MSB before entering the signed product
  assign w_prod = PROD_W'(i_sample) * PROD_W'($signed({1'b0, i_gain}));

  // Arithmetic shift floors toward minus infinity; hold when no sample moves
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
    end else if (i_valid) begin
      r_shift <= w_prod >>> FRAC_W;
    end
  end

  // Clamp to the DAC range and flag any value that had to be clamped
  always_comb begin
    w_sat  = r_shift[OUT_W-1:0];
    o_clip = 1'b0;
    if (r_shift > SAT_HI) begin
      w_sat  = OUT_W'(OUT_MAX);
      o_clip = 1'b1;
    end else if (r_shift < SAT_LO) begin
      w_sat  = OUT_W'(OUT_MIN);
      o_clip = 1'b1;
    end
  end

  assign o_code = dac_format(w_sat);

endmodule

// File: rtl/dac_out_stage.sv
// DAC output stage: shared soft-mute gain ramp, two scaled/saturated channels,
// registered HSMC pin codes and clip statistics. Latency is 3 clocks from
// in_valid to out_valid at full throughput.
// Optional build macro: DAC_OFFSET_BINARY_EN (offset-binary pin codes).
module dac_out_stage
  import dac_out_pkg::*;
#(
  parameter int RAMP_DIV  = 25,
  parameter int RAMP_STEP = 1
)
(
  input  logic             clk,
  input  logic             rst,
  dac_out_stage_if.slave   bus
);

  localparam logic [1:0] ST_UNMUTED   = 2'(UNMUTED);
  localparam logic [1:0] ST_RAMP_DOWN = 2'(RAMP_DOWN);
  localparam logic [1:0] ST_MUTED     = 2'(MUTED);
  localparam logic [1:0] ST_RAMP_UP   = 2'(RAMP_UP);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [GAIN_W-1:0] G_UNITY  = GAIN_W'(GAIN_UNITY);
  localparam logic [GAIN_W-1:0] STEP_G   = GAIN_W'(RAMP_STEP);
  localparam logic [GAIN_W-1:0] UP_LIMIT = G_UNITY - STEP_G;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // Gain FSM and ramp divider
  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [GAIN_W-1:0] r_gain;
  logic [GAIN_W-1:0] w_gain_next;
  logic [DIV_W-1:0]  r_div;
  logic              w_tick;
  logic              w_state_chg;

  // Pipeline
  logic              r_v_s1;
  logic              r_v_s2;
  logic              r_v_s3;
  logic [GAIN_W-1:0] r_g_s1;
  logic [OUT_W-1:0]  r_da;
  logic [OUT_W-1:0]  r_db;

  // Clip status
  logic              r_clip_a;
  logic              r_clip_b;
  logic [CNT_W-1:0]  r_clip_cnt;

  // Per-channel wiring
  logic signed [IN_W-1:0] w_in   [NUM_CH];
  logic [OUT_W-1:0]       w_code [NUM_CH];
  logic                   w_clip [NUM_CH];

  assign w_tick      = (r_div == DIV_LAST);
  assign w_state_chg = (w_state_next != r_state);

  // Next gain/state: a mute reversal keeps the current gain so the ramp
  // simply turns around without a step in the output
  always_comb begin
    w_state_next = r_state;
    w_gain_next  = r_gain;
    case (r_state)
      ST_UNMUTED: begin
        w_gain_next = G_UNITY;
        if (bus.mute) begin
          w_state_next = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        if (!bus.mute) begin
          w_state_next = ST_RAMP_UP;
        end else if (w_tick) begin
          if (r_gain <= STEP_G) begin
            w_gain_next  = '0;
            w_state_next = ST_MUTED;
          end else begin
            w_gain_next = r_gain - STEP_G;
          end
        end
      end
      ST_MUTED: begin
        w_gain_next = '0;
        if (!bus.mute) begin
          w_state_next = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (bus.mute) begin
          w_state_next = ST_RAMP_DOWN;
        end else if (w_tick) begin
          if (r_gain >= UP_LIMIT) begin
            w_gain_next  = G_UNITY;
            w_state_next = ST_UNMUTED;
          end else begin
            w_gain_next = r_gain + STEP_G;
          end
        end
      end
      default: begin
        w_state_next = ST_UNMUTED;
        w_gain_next  = G_UNITY;
      end
    endcase
  end

  // Gain FSM state and gain register; reset lands on unity regardless of mute
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_UNMUTED;
      r_gain  <= G_UNITY;
    end else begin
      r_state <= w_state_next;
      r_gain  <= w_gain_next;
    end
  end

  // Ramp tick divider, restarted on every state change so a fresh ramp
  // always waits a full RAMP_DIV period before its first step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_state_chg || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // S1 shared part: valid bit and the gain that applies to this sample pair
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_s1 <= 1'b0;
      r_g_s1 <= G_UNITY;
    end else begin
      r_v_s1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_g_s1 <= r_gain;
      end
    end
  end

  assign w_in[0] = bus.in_a;
  assign w_in[1] = bus.in_b;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    logic signed [IN_W-1:0] r_sample_s1;

    // S1 per-channel sample capture
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sample_s1 <= '0;
      end else if (bus.in_valid) begin
        r_sample_s1 <= w_in[gi];
      end
    end

    dac_chan_scale u_scale (
      .clk      (clk),
      .rst      (rst),
      .i_valid  (r_v_s1),
      .i_sample (r_sample_s1),
      .i_gain   (r_g_s1),
      .o_code   (w_code[gi]),
      .o_clip   (w_clip[gi])
    );
  end

  // S2 valid tracks the registered multiply/shift inside each channel
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_s2 <= 1'b0;
    end else begin
      r_v_s2 <= r_v_s1;
    end
  end

  // S3 output registers: pins hold their last code between samples
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_s3 <= 1'b0;
      r_da   <= DAC_ZERO;
      r_db   <= DAC_ZERO;
    end else begin
      r_v_s3 <= r_v_s2;
      if (r_v_s2) begin
        r_da <= w_code[0];
        r_db <= w_code[1];
      end
    end
  end

  // Clip statistics; a clear wins over a clip landing in the same cycle
  always_ff @(posedge clk) begin
    if (rst || bus.clip_clr) begin
      r_clip_a   <= 1'b0;
      r_clip_b   <= 1'b0;
      r_clip_cnt <= '0;
    end else if (r_v_s2 && (w_clip[0] || w_clip[1])) begin
      r_clip_a <= r_clip_a | w_clip[0];
      r_clip_b <= r_clip_b | w_clip[1];
      if (r_clip_cnt != CNT_MAX) begin
        r_clip_cnt <= r_clip_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.HSMC_DA   = r_da;
  assign bus.HSMC_DB   = r_db;
  assign bus.out_valid = r_v_s3;
  assign bus.muted     = (r_state == ST_MUTED);
  assign bus.clip_a    = r_clip_a;
  assign bus.clip_b    = r_clip_b;
  assign bus.clip_cnt  = r_clip_cnt;

endmodule
